// File: rtl/rs_pair_pkg.sv
// Shared definitions for the reservation stations and the dispatch unit:
// RS IDs, instruction-type codes, the "operand ready" tag and entry states.
package rs_pair_pkg;

    localparam logic [3:0] ADD_0   = 4'b0001;
    localparam logic [3:0] ADD_1   = 4'b0010;
    localparam logic [3:0] MULT_0  = 4'b0011;
    localparam logic [3:0] MULT_1  = 4'b0100;
    localparam logic [3:0] FETCH_0 = 4'b0101;
    localparam logic [3:0] FETCH_1 = 4'b0110;
    localparam logic [3:0] STORE_0 = 4'b0111;
    localparam logic [3:0] STORE_1 = 4'b1000;

    // A source tag of 0 means the value is already present.
    localparam logic [3:0] TAG_READY = 4'b0000;

    typedef enum logic [1:0] {
        InstrAdd,
        InstrMult,
        InstrFetch,
        InstrStore
    } instr_type_e;

    typedef enum logic [1:0] {
        StFree,
        StWait,
        StReady,
        StIssued
    } rs_state_e;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station entry: lifecycle FSM, operand latches, CDB snoop
// and same-cycle dispatch bypass.
module rs_entry
    import rs_pair_pkg::*;
#(
    parameter int unsigned         TAG_LEN  = 4,
    parameter int unsigned         DATA_WID = 16,
    parameter logic [TAG_LEN-1:0]  RS_ID    = TAG_LEN'(ADD_0)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                disp_i,
    input  logic [TAG_LEN-1:0]  disp_tag0_i,
    input  logic [TAG_LEN-1:0]  disp_tag1_i,
    input  logic [DATA_WID-1:0] disp_val0_i,
    input  logic [DATA_WID-1:0] disp_val1_i,
    input  logic                cdb_valid_i,
    input  logic [TAG_LEN-1:0]  cdb_tag_i,
    input  logic [DATA_WID-1:0] cdb_data_i,
    input  logic                issue_i,
    output logic                ready_o,
    output logic                free_o,
    output logic                done_o,
    output logic [DATA_WID-1:0] op_a_o,
    output logic [DATA_WID-1:0] op_b_o
);

    localparam logic [TAG_LEN-1:0] TagRdy = TAG_LEN'(TAG_READY);

    rs_state_e             state_q, state_d;
    logic [TAG_LEN-1:0]    tag0_q, tag0_d, tag1_q, tag1_d;
    logic [DATA_WID-1:0]   val0_q, val0_d, val1_q, val1_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFree;
            tag0_q  <= '0;
            tag1_q  <= '0;
            val0_q  <= '0;
            val1_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tag0_q  <= tag0_d;
            tag1_q  <= tag1_d;
            val0_q  <= val0_d;
            val1_q  <= val1_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tag0_d  = tag0_q;
        tag1_d  = tag1_q;
        val0_d  = val0_q;
        val1_d  = val1_q;
        done_d  = 1'b0;
        unique case (state_q)
            StFree: begin
                if (disp_i) begin
                    tag0_d = disp_tag0_i;
                    tag1_d = disp_tag1_i;
                    val0_d = disp_val0_i;
                    val1_d = disp_val1_i;
                    // Bypass: a producer broadcasting in the dispatch cycle
                    if (cdb_valid_i && disp_tag0_i != TagRdy && disp_tag0_i == cdb_tag_i) begin
                        tag0_d = TagRdy;
                        val0_d = cdb_data_i;
                    end
                    if (cdb_valid_i && disp_tag1_i != TagRdy && disp_tag1_i == cdb_tag_i) begin
                        tag1_d = TagRdy;
                        val1_d = cdb_data_i;
                    end
                    state_d = (tag0_d == TagRdy && tag1_d == TagRdy) ? StReady : StWait;
                end
            end
            StWait: begin
                if (cdb_valid_i && tag0_q != TagRdy && tag0_q == cdb_tag_i) begin
                    tag0_d = TagRdy;
                    val0_d = cdb_data_i;
                end
                if (cdb_valid_i && tag1_q != TagRdy && tag1_q == cdb_tag_i) begin
                    tag1_d = TagRdy;
                    val1_d = cdb_data_i;
                end
                if (tag0_d == TagRdy && tag1_d == TagRdy) state_d = StReady;
            end
            StReady: begin
                if (issue_i) state_d = StIssued;
            end
            StIssued: begin
                if (cdb_valid_i && cdb_tag_i == RS_ID) begin
                    state_d = StFree;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StFree;
        endcase
    end

    always_comb begin
        ready_o = (state_q == StReady);
        free_o  = (state_q == StFree);
        done_o  = done_q;
        op_a_o  = val0_q;
        op_b_o  = val1_q;
    end

endmodule

// File: rtl/rs_pair.sv
// Two-entry reservation station: dispatch decode and error detection, age
// tracking and a registered, stall-stable issue port to the functional unit.
module rs_pair
    import rs_pair_pkg::*;
#(
    parameter int unsigned        TAG_LEN  = 4,
    parameter int unsigned        DATA_WID = 16,
    parameter logic [TAG_LEN-1:0] RS_ID_0  = TAG_LEN'(ADD_0),
    parameter logic [TAG_LEN-1:0] RS_ID_1  = TAG_LEN'(ADD_1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                disp1_valid,
    input  logic [TAG_LEN-1:0]  disp1_rs,
    input  logic [TAG_LEN-1:0]  disp1_tag0,
    input  logic [TAG_LEN-1:0]  disp1_tag1,
    input  logic [DATA_WID-1:0] disp1_val0,
    input  logic [DATA_WID-1:0] disp1_val1,
    input  logic                disp2_valid,
    input  logic [TAG_LEN-1:0]  disp2_rs,
    input  logic [TAG_LEN-1:0]  disp2_tag0,
    input  logic [TAG_LEN-1:0]  disp2_tag1,
    input  logic [DATA_WID-1:0] disp2_val0,
    input  logic [DATA_WID-1:0] disp2_val1,
    input  logic                cdb_valid,
    input  logic [TAG_LEN-1:0]  cdb_tag,
    input  logic [DATA_WID-1:0] cdb_data,
    output logic                fu_valid,
    input  logic                fu_ready,
    output logic [TAG_LEN-1:0]  fu_tag,
    output logic [DATA_WID-1:0] fu_op_a,
    output logic [DATA_WID-1:0] fu_op_b,
    output logic [1:0]          done,
    output logic [1:0]          busy,
    output logic                disp_err
);

    logic                hit1, hit2, tgt1, tgt2, acc1, acc2, err1, err2;
    logic [1:0]          free, ready, done_e, entry_disp, issue, avail;
    logic [TAG_LEN-1:0]  e_tag0 [2];
    logic [TAG_LEN-1:0]  e_tag1 [2];
    logic [DATA_WID-1:0] e_val0 [2];
    logic [DATA_WID-1:0] e_val1 [2];
    logic [DATA_WID-1:0] op_a [2];
    logic [DATA_WID-1:0] op_b [2];

    logic                age_q, age_d;
    logic                err_q, err_d;
    logic                fu_valid_q, fu_valid_d, fu_sel_q, fu_sel_d, hs;
    logic [TAG_LEN-1:0]  fu_tag_q, fu_tag_d;
    logic [DATA_WID-1:0] fu_op_a_q, fu_op_a_d, fu_op_b_q, fu_op_b_d;

    always_comb begin
        hit1 = disp1_valid && (disp1_rs == RS_ID_0 || disp1_rs == RS_ID_1);
        hit2 = disp2_valid && (disp2_rs == RS_ID_0 || disp2_rs == RS_ID_1);
        tgt1 = (disp1_rs == RS_ID_1);
        tgt2 = (disp2_rs == RS_ID_1);
        acc1 = hit1 && free[tgt1];
        err1 = hit1 && !free[tgt1];
        // Bus 1 wins when both buses name the same free entry
        acc2 = hit2 && free[tgt2] && !(acc1 && tgt1 == tgt2);
        err2 = hit2 && !acc2;
        err_d = err1 || err2;
        for (int k = 0; k < 2; k++) begin
            entry_disp[k] = (acc1 && tgt1 == 1'(k)) || (acc2 && tgt2 == 1'(k));
            if (acc1 && tgt1 == 1'(k)) begin
                e_tag0[k] = disp1_tag0;
                e_tag1[k] = disp1_tag1;
                e_val0[k] = disp1_val0;
                e_val1[k] = disp1_val1;
            end else begin
                e_tag0[k] = disp2_tag0;
                e_tag1[k] = disp2_tag1;
                e_val0[k] = disp2_val0;
                e_val1[k] = disp2_val1;
            end
        end
    end

    // age_q holds the index of the older entry
    always_comb begin
        age_d = age_q;
        if (entry_disp[0] && entry_disp[1]) age_d = tgt1;
        else if (entry_disp[0])             age_d = 1'b1;
        else if (entry_disp[1])             age_d = 1'b0;
    end

    for (genvar k = 0; k < 2; k++) begin : g_entry
        rs_entry #(
            .TAG_LEN  (TAG_LEN),
            .DATA_WID (DATA_WID),
            .RS_ID    ((k == 0) ? RS_ID_0 : RS_ID_1)
        ) u_entry (
            .clk         (clk),
            .rst_n       (rst_n),
            .disp_i      (entry_disp[k]),
            .disp_tag0_i (e_tag0[k]),
            .disp_tag1_i (e_tag1[k]),
            .disp_val0_i (e_val0[k]),
            .disp_val1_i (e_val1[k]),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_tag),
            .cdb_data_i  (cdb_data),
            .issue_i     (issue[k]),
            .ready_o     (ready[k]),
            .free_o      (free[k]),
            .done_o      (done_e[k]),
            .op_a_o      (op_a[k]),
            .op_b_o      (op_b[k])
        );
    end

    always_comb begin
        hs       = fu_valid_q && fu_ready;
        issue[0] = hs && !fu_sel_q;
        issue[1] = hs && fu_sel_q;
        avail    = ready & ~issue;
        fu_valid_d = fu_valid_q;
        fu_sel_d   = fu_sel_q;
        fu_tag_d   = fu_tag_q;
        fu_op_a_d  = fu_op_a_q;
        fu_op_b_d  = fu_op_b_q;
        // Presented operands stay frozen while the FU stalls
        if (!fu_valid_q || fu_ready) begin
            fu_valid_d = |avail;
            fu_sel_d   = (avail[0] && avail[1]) ? age_q : avail[1];
            if (|avail) begin
                fu_tag_d  = fu_sel_d ? RS_ID_1 : RS_ID_0;
                fu_op_a_d = op_a[fu_sel_d];
                fu_op_b_d = op_b[fu_sel_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q      <= 1'b0;
            err_q      <= 1'b0;
            fu_valid_q <= 1'b0;
            fu_sel_q   <= 1'b0;
            fu_tag_q   <= '0;
            fu_op_a_q  <= '0;
            fu_op_b_q  <= '0;
        end else begin
            age_q      <= age_d;
            err_q      <= err_d;
            fu_valid_q <= fu_valid_d;
            fu_sel_q   <= fu_sel_d;
            fu_tag_q   <= fu_tag_d;
            fu_op_a_q  <= fu_op_a_d;
            fu_op_b_q  <= fu_op_b_d;
        end
    end

    always_comb begin
        fu_valid = fu_valid_q;
        fu_tag   = fu_tag_q;
        fu_op_a  = fu_op_a_q;
        fu_op_b  = fu_op_b_q;
        done     = done_e;
        busy     = ~free;
        disp_err = err_q;
    end

endmodule
